// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared encodings for the NPC program-counter unit.
// PC_OP_* values, FSM state encodings and the default reset vector.
package pc_unit_pkg;

    localparam int PC_OP_W = 4;

    localparam logic [PC_OP_W-1:0] PC_OP_SEQ  = 4'd0;
    localparam logic [PC_OP_W-1:0] PC_OP_JAL  = 4'd1;
    localparam logic [PC_OP_W-1:0] PC_OP_JALR = 4'd2;
    localparam logic [PC_OP_W-1:0] PC_OP_BEQ  = 4'd3;
    localparam logic [PC_OP_W-1:0] PC_OP_BNE  = 4'd4;
    localparam logic [PC_OP_W-1:0] PC_OP_BLT  = 4'd5;
    localparam logic [PC_OP_W-1:0] PC_OP_BGE  = 4'd6;
    localparam logic [PC_OP_W-1:0] PC_OP_BLTU = 4'd7;
    localparam logic [PC_OP_W-1:0] PC_OP_BGEU = 4'd8;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

endpackage

// File: rtl/pc_unit_branch_cmp.sv
// pc_branch_cmp: combinational branch condition evaluation.
// Non-branch opcodes report not-taken.
module pc_branch_cmp
    import pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [PC_OP_W-1:0] i_pc_op,
    input  logic [XLEN-1:0]    i_src1,
    input  logic [XLEN-1:0]    i_src2,
    output logic               o_taken
);

    // Select the compare that matches the branch opcode
    always_comb begin
        o_taken = 1'b0;
        case (i_pc_op)
            PC_OP_BEQ:  o_taken = (i_src1 == i_src2);
            PC_OP_BNE:  o_taken = (i_src1 != i_src2);
            PC_OP_BLT:  o_taken = ($signed(i_src1) <  $signed(i_src2));
            PC_OP_BGE:  o_taken = ($signed(i_src1) >= $signed(i_src2));
            PC_OP_BLTU: o_taken = (i_src1 <  i_src2);
            PC_OP_BGEU: o_taken = (i_src1 >= i_src2);
            default:    o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC register with IFU/EXU handshakes and next-PC logic.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned jump/branch targets raise
// exc_misalign and redirect to trap_vec; otherwise target low bits are cleared.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int              IALIGN_BITS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    pc,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [PC_OP_W-1:0] pc_op,
    input  logic [XLEN-1:0]    src1,
    input  logic [XLEN-1:0]    src2,
    input  logic [XLEN-1:0]    imm,
    input  logic               trap_req,
    input  logic [XLEN-1:0]    trap_vec,
    input  logic               mret_req,
    input  logic [XLEN-1:0]    mepc,
    output logic               retire,
    output logic               exc_misalign,
    output logic [XLEN-1:0]    exc_tval
);

    localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << IALIGN_BITS) - XLEN'(1));

    logic [0:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_retire;

    logic            w_taken;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_trap_tgt;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next;

    pc_branch_cmp #(.XLEN(XLEN)) u_cmp (
        .i_pc_op (pc_op),
        .i_src1  (src1),
        .i_src2  (src2),
        .o_taken (w_taken)
    );

    // Direct-mode trap entry: mtvec low two bits are mode, not address
    assign w_trap_tgt = trap_vec & ~XLEN'(3);
    assign w_seq      = r_pc + FOUR;
    assign w_br_tgt   = r_pc + imm;
    assign w_jalr_tgt = (src1 + imm) & ~XLEN'(1);

    // Raw control-flow target before alignment handling
    always_comb begin
        w_target = w_seq;
        case (pc_op)
            PC_OP_JAL:  w_target = w_br_tgt;
            PC_OP_JALR: w_target = w_jalr_tgt;
            PC_OP_BEQ, PC_OP_BNE, PC_OP_BLT,
            PC_OP_BGE, PC_OP_BLTU, PC_OP_BGEU:
                        w_target = w_taken ? w_br_tgt : w_seq;
            default:    w_target = w_seq;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic            w_misalign;
    logic            r_exc_misalign;
    logic [XLEN-1:0] r_exc_tval;

    // Only jump/branch targets are checked; trap and mret targets are trusted
    assign w_misalign = !trap_req && !mret_req && ((w_target & ~ALIGN_MASK) != '0);

    // Trap beats mret beats a misaligned redirect beats the normal target
    always_comb begin
        w_next = w_target;
        if (trap_req)        w_next = w_trap_tgt;
        else if (mret_req)   w_next = mepc;
        else if (w_misalign) w_next = w_trap_tgt;
    end

    // Exception pulse and faulting address, registered with the commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_misalign <= 1'b0;
            r_exc_tval     <= '0;
        end else begin
            r_exc_misalign <= 1'b0;
            r_exc_tval     <= '0;
            if (r_state == ST_EXEC && ex_valid && w_misalign) begin
                r_exc_misalign <= 1'b1;
                r_exc_tval     <= w_target;
            end
        end
    end

    assign exc_misalign = r_exc_misalign;
    assign exc_tval     = r_exc_tval;
`else
    // Without the exception path, illegal low target bits are simply dropped
    always_comb begin
        w_next = w_target & ALIGN_MASK;
        if (trap_req)      w_next = w_trap_tgt;
        else if (mret_req) w_next = mepc;
    end

    assign exc_misalign = 1'b0;
    assign exc_tval     = '0;
`endif

    // FETCH/EXEC handshake FSM and PC commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_VECTOR;
            r_retire <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_FETCH: if (if_ready) r_state <= ST_EXEC;
                ST_EXEC: if (ex_valid) begin
                    r_pc     <= w_next;
                    r_retire <= 1'b1;
                    r_state  <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign if_valid = (r_state == ST_FETCH);
    assign ex_ready = (r_state == ST_EXEC);
    assign pc       = r_pc;
    assign retire   = r_retire;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit. The stimulus process predicts each
// committed PC from the instruction semantics and queues it; a monitor checks
// every retire pulse against the queue head. Honours PC_MISALIGN_TRAP_EN.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h8000_0000;

    typedef struct {
        logic [31:0] npc;
        logic        exc;
        logic [31:0] tval;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid, if_ready = 1'b0;
    logic [31:0] pc;
    logic        ex_valid = 1'b0, ex_ready;
    logic [3:0]  pc_op = 4'd0;
    logic [31:0] src1 = '0, src2 = '0, imm = '0, trap_vec = '0, mepc = '0;
    logic        trap_req = 1'b0, mret_req = 1'b0;
    logic        retire, exc_misalign;
    logic [31:0] exc_tval;

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  exp_q[$];
    logic [31:0] model_pc;

    pc_unit dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .pc(pc),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .pc_op(pc_op), .src1(src1),
        .src2(src2), .imm(imm), .trap_req(trap_req), .trap_vec(trap_vec),
        .mret_req(mret_req), .mepc(mepc), .retire(retire),
        .exc_misalign(exc_misalign), .exc_tval(exc_tval)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Reference next-PC from the instruction semantics
    function automatic exp_t predict(input logic [31:0] cur, input logic [3:0] op,
                                     input logic [31:0] s1, input logic [31:0] s2,
                                     input logic [31:0] im, input logic tr,
                                     input logic [31:0] tv, input logic mr,
                                     input logic [31:0] me);
        exp_t e;
        logic [31:0] tgt;
        logic taken;
        e.exc = 1'b0;
        e.tval = '0;
        taken = 1'b0;
        case (op)
            4'd3: taken = (s1 == s2);
            4'd4: taken = (s1 != s2);
            4'd5: taken = (int'(s1) < int'(s2));
            4'd6: taken = (int'(s1) >= int'(s2));
            4'd7: taken = (s1 < s2);
            4'd8: taken = (s1 >= s2);
            default: taken = 1'b0;
        endcase
        if (op == 4'd1 || taken) tgt = cur + im;
        else if (op == 4'd2)     tgt = (s1 + im) - ((s1 + im) % 2);
        else                     tgt = cur + 32'd4;
        if (tr)      e.npc = tv - (tv % 4);
        else if (mr) e.npc = me;
        else begin
`ifdef PC_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin
                e.exc  = 1'b1;
                e.tval = tgt;
                e.npc  = tv - (tv % 4);
            end else e.npc = tgt;
`else
            e.npc = tgt - (tgt % 4);
`endif
        end
        return e;
    endfunction

    // Monitor: every retire must match the oldest predicted commit
    always @(negedge clk) begin
        if (!rst && retire) begin
            if (exp_q.size() == 0) begin
                check("retire_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_pc", pc, e.npc);
                check("commit_exc", {31'd0, exc_misalign}, {31'd0, e.exc});
                check("commit_tval", exc_tval, e.tval);
            end
        end
    end

    // One instruction through FETCH (with optional IFU stall) and EXEC
    task automatic issue(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] im, input logic tr, input logic [31:0] tv,
                         input logic mr, input logic [31:0] me, input int stall, input int exwait);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("fetch_wait", {31'd0, if_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            if_ready = 1'b0;
            ex_valid = 1'($urandom_range(0, 1));
            pc_op = 4'($urandom); imm = $urandom; trap_req = 1'($urandom); mret_req = 1'($urandom);
            @(posedge clk); #1;
            check("stall_pc", pc, model_pc);
            check("stall_if_valid", {31'd0, if_valid}, 32'd1);
            check("stall_ex_ready", {31'd0, ex_ready}, 32'd0);
            check("stall_retire", {31'd0, retire}, 32'd0);
        end
        ex_valid = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
        if_ready = 1'b1;
        @(posedge clk); #1;
        if_ready = 1'b0;
        check("exec_ex_ready", {31'd0, ex_ready}, 32'd1);
        check("exec_if_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < exwait; i++) begin
            pc_op = 4'($urandom); src1 = $urandom; trap_req = 1'($urandom);
            @(posedge clk); #1;
            check("exec_hold_pc", pc, model_pc);
        end
        pc_op = op; src1 = s1; src2 = s2; imm = im;
        trap_req = tr; trap_vec = tv; mret_req = mr; mepc = me;
        begin
            exp_t e;
            e = predict(model_pc, op, s1, s2, im, tr, tv, mr, me);
            exp_q.push_back(e);
            model_pc = e.npc;
        end
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
        check("if_valid_after_commit", {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_pc = RV;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, RV);
        check("rst_if_valid", {31'd0, if_valid}, 32'd1);
        check("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_exc", {31'd0, exc_misalign}, 32'd0);
        check("rst_tval", exc_tval, 32'd0);
        rst = 1'b0;

        // sequential run, 80000000 -> ...0C -> ...10
        repeat (4) issue(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("seq_pc", pc, 32'h8000_0010);
        // signed vs unsigned compare of the same operands
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, -32'sd8, 0, 0, 0, 0, 0, 1);
        check("blt_pc", pc, 32'h8000_0008);
        repeat (2) issue(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, -32'sd8, 0, 0, 0, 0, 0, 0);
        check("bltu_pc", pc, 32'h8000_0014);
        // misaligned jalr target
        issue(4'd2, 32'h8000_1003, 0, 0, 0, 32'h8000_0100, 0, 0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check("jalr_mis_pc", pc, 32'h8000_0100);
`else
        check("jalr_pc", pc, 32'h8000_1000);
`endif
        // trap beats mret beats jal; then mret
        issue(4'd1, 0, 0, 32'h40, 1, 32'h8000_0103, 1, 32'h8000_0200, 0, 0);
        check("trap_pc", pc, 32'h8000_0100);
        issue(4'd0, 0, 0, 0, 0, 0, 1, 32'h8000_0040, 5, 0);
        check("mret_pc", pc, 32'h8000_0040);
        // wrap at top of address space
        issue(4'd0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        issue(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc", pc, 32'h0000_0000);

        // reset concurrent with ex_valid in EXEC
        if_ready = 1'b1;
        @(posedge clk); #1;
        if_ready = 1'b0;
        pc_op = 4'd1; imm = 32'h100; ex_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0;
        model_pc = RV;
        check("rst_exec_pc", pc, RV);
        check("rst_exec_if_valid", {31'd0, if_valid}, 32'd1);
        check("rst_exec_retire", {31'd0, retire}, 32'd0);

        // randomized instruction stream
        for (int k = 0; k < 200; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b, im, tv, me;
            logic        tr, mr;
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? a : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            im = ($urandom_range(0, 7) == 0) ? 32'($signed(10'($urandom))) : (32'($signed(10'($urandom))) << 2);
            tv = $urandom;
            me = $urandom & ~32'd3;
            tr = ($urandom_range(0, 15) == 0);
            mr = ($urandom_range(0, 15) == 0);
            issue(op, a, b, im, tr, tv, mr, me, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
